// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 key-schedule slice.
// The S-box is computed (inverse via x^254, then the affine map) rather than tabulated.
package aes_pkg;
  localparam int KW = 128;
  localparam int WW = 32;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} state_t;

  function automatic logic [7:0] xtime8(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [WW-1:0] rot_word(input logic [WW-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] s;
    p = '0;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      s = xtime8(s);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8); zero maps to zero as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] t;
    t = x;
    for (int i = 0; i < 6; i++) t = gf_mul(gf_mul(t, t), x);
    return gf_mul(t, t);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction
endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// Key-load and round-key read bus between the key source / round sequencer (master)
// and the key-schedule controller (slave).
interface aes_key_sched_ctrl_if #(parameter int KW = 128);
  logic          key_valid;
  logic [KW-1:0] key;
  logic          key_ready;
  logic          busy;
  logic          keys_ready;
  logic          rd_req;
  logic [3:0]    rd_idx;
  logic          rd_valid;
  logic          rd_err;
  logic [KW-1:0] rd_key;

  modport master (
    output key_valid, key, rd_req, rd_idx,
    input  key_ready, busy, keys_ready, rd_valid, rd_err, rd_key
  );

  modport slave (
    input  key_valid, key, rd_req, rd_idx,
    output key_ready, busy, keys_ready, rd_valid, rd_err, rd_key
  );
endinterface

// File: rtl/aes_key_round_dp.sv
// One AES-128 key-expansion round: RotWord -> 4 registered S-boxes (1-cycle latency),
// then the rcon XOR and the chained word XORs, combinational from the S-box register.
module aes_key_round_dp
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic [KW-1:0] prev_key,
  input  logic [7:0]    rcon,
  output logic [KW-1:0] next_key
);
  logic [WW-1:0] rot;
  logic [WW-1:0] sub_next;
  logic [WW-1:0] sub_reg;
  logic [WW-1:0] w0, w1, w2, w3;

  assign rot = rot_word(prev_key[WW-1:0]);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      assign sub_next[8*gi +: 8] = sbox(rot[8*gi +: 8]);
    end
  endgenerate

  // S-box output register; valid one cycle after prev_key settles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sub_reg <= '0;
    else          sub_reg <= sub_next;
  end

  assign w0 = prev_key[127:96] ^ sub_reg ^ {rcon, 24'h0};
  assign w1 = w0 ^ prev_key[95:64];
  assign w2 = w1 ^ prev_key[63:32];
  assign w3 = w2 ^ prev_key[31:0];
  assign next_key = {w0, w1, w2, w3};
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule controller: expands one cipher key into NR+1 round
// keys (one round per 2 cycles) and serves them through a registered read port.
// Optional feature macro: AES_KEYSCHED_ZEROIZE_EN adds the zeroize input, which
// wipes the store and read register, forces IDLE and discards in-flight work.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NR = 10
)(
  input logic clk,
  input logic reset_n,
`ifdef AES_KEYSCHED_ZEROIZE_EN
  input logic zeroize,
`endif
  aes_key_sched_ctrl_if.slave bus
);
  localparam logic [3:0] NR_L = 4'(NR);

  state_t        state_reg;
  logic [3:0]    round_reg;
  logic [7:0]    rcon_reg;
  logic [KW-1:0] prev_reg;     // most recent round key, feeds the datapath
  logic          key_ready_reg, busy_reg, keys_ready_reg;
  logic          rd_valid_reg, rd_err_reg;
  logic [KW-1:0] rd_key_reg;
  logic [KW-1:0] rk [0:NR];
  logic [KW-1:0] next_key;
  logic          clear;
  logic          accept;
  logic          rk_we;
  logic [3:0]    rk_waddr;
  logic [KW-1:0] rk_wdata;

`ifdef AES_KEYSCHED_ZEROIZE_EN
  assign clear = zeroize;
`else
  assign clear = 1'b0;
`endif

  // key_ready is only ever high in IDLE/DONE
  assign accept = key_ready_reg && bus.key_valid && !clear;

  aes_key_round_dp u_dp (
    .clk      (clk),
    .reset_n  (reset_n),
    .prev_key (prev_reg),
    .rcon     (rcon_reg),
    .next_key (next_key)
  );

  // Store write port: the cipher key on acceptance, otherwise each MIX result
  always_comb begin
    rk_we    = 1'b0;
    rk_waddr = '0;
    rk_wdata = bus.key;
    if (!clear) begin
      if (accept) begin
        rk_we = 1'b1;
      end else if (state_reg == MIX) begin
        rk_we    = 1'b1;
        rk_waddr = round_reg;
        rk_wdata = next_key;
      end
    end
  end

`ifdef AES_KEYSCHED_ZEROIZE_EN
  // Round-key store, wiped on reset and while zeroize is held
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else if (rk_we) begin
      rk[rk_waddr] <= rk_wdata;
    end
  end
`else
  // Round-key store, overwritten only by new expansions
  always_ff @(posedge clk) begin
    if (rk_we) rk[rk_waddr] <= rk_wdata;
  end
`endif

  // Sequencing FSM with registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      round_reg      <= '0;
      rcon_reg       <= RCON_INIT;
      prev_reg       <= '0;
      key_ready_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      keys_ready_reg <= 1'b0;
    end else if (clear) begin
      state_reg      <= IDLE;
      round_reg      <= '0;
      rcon_reg       <= RCON_INIT;
      prev_reg       <= '0;
      key_ready_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      keys_ready_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (!key_ready_reg) begin
            key_ready_reg <= 1'b1;
          end else if (bus.key_valid) begin
            prev_reg       <= bus.key;
            round_reg      <= 4'd1;
            rcon_reg       <= RCON_INIT;
            keys_ready_reg <= 1'b0;
            key_ready_reg  <= 1'b0;
            busy_reg       <= 1'b1;
            state_reg      <= SUB;
          end
        end
        SUB: state_reg <= MIX;
        MIX: begin
          prev_reg <= next_key;
          rcon_reg <= xtime8(rcon_reg);
          if (round_reg == NR_L) begin
            state_reg      <= DONE;
            keys_ready_reg <= 1'b1;
            key_ready_reg  <= 1'b1;
            busy_reg       <= 1'b0;
          end else begin
            round_reg <= round_reg + 4'd1;
            state_reg <= SUB;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Registered read port; requests are honoured only once all keys are valid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_reg <= 1'b0;
      rd_err_reg   <= 1'b0;
      rd_key_reg   <= '0;
    end else if (clear) begin
      rd_valid_reg <= 1'b0;
      rd_err_reg   <= 1'b0;
      rd_key_reg   <= '0;
    end else begin
      rd_valid_reg <= bus.rd_req && keys_ready_reg;
      if (bus.rd_req && keys_ready_reg) begin
        if (bus.rd_idx > NR_L) begin
          rd_err_reg <= 1'b1;
          rd_key_reg <= '0;
        end else begin
          rd_err_reg <= 1'b0;
          rd_key_reg <= rk[bus.rd_idx];
        end
      end
    end
  end

  assign bus.key_ready  = key_ready_reg;
  assign bus.busy       = busy_reg;
  assign bus.keys_ready = keys_ready_reg;
  assign bus.rd_valid   = rd_valid_reg;
  assign bus.rd_err     = rd_err_reg;
  assign bus.rd_key     = rd_key_reg;
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl: FIPS-197 and zero-key vectors applied
// from tables, read responses checked through an expected-response queue, plus
// hand-written timing, drop, reset and (with AES_KEYSCHED_ZEROIZE_EN) zeroize sequences.
module tb_aes_key_sched_ctrl;
  typedef struct packed {
    logic [3:0]   idx;
    logic         err;
    logic [127:0] key;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
`ifdef AES_KEYSCHED_ZEROIZE_EN
  logic zeroize = 1'b0;
`endif
  int tests = 0;
  int fails = 0;
  vec_t exp_q[$];
  vec_t fips_vec [12];
  vec_t zero_vec [4];
  logic [127:0] fips_rk [11];
  logic [127:0] fips_key;

  aes_key_sched_ctrl_if #(.KW(128)) bus();

  aes_key_sched_ctrl #(.NR(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef AES_KEYSCHED_ZEROIZE_EN
    .zeroize (zeroize),
`endif
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every rd_valid pulse must match the oldest expectation
  always @(negedge clk) begin
    vec_t e;
    if (bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rd_valid: got rd_valid=1 with rd_key=%h required no response", bus.rd_key);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("rd_err[idx%0d]", e.idx), 128'(bus.rd_err), 128'(e.err));
        check($sformatf("rd_key[idx%0d]", e.idx), bus.rd_key, e.key);
        $display("[TB] read idx=%0d err=%0b key=%h", e.idx, bus.rd_err, bus.rd_key);
      end
    end
  end

  task automatic issue(input vec_t v);
    bus.rd_req = 1'b1;
    bus.rd_idx = v.idx;
    exp_q.push_back(v);
    tick();
  endtask

  task automatic drain();
    int w;
    w = 0;
    bus.rd_req = 1'b0;
    while (exp_q.size() != 0 && w < 10) begin
      tick();
      w++;
    end
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
  endtask

  // Accept a key and verify the 20-cycle busy window; side=1 adds a dropped read at
  // cycle 3 and an ignored key_valid at cycle 5; rd_old reads rk[0] in the accept cycle
  task automatic load_key(input logic [127:0] k, input bit rd_old, input bit side);
    int w;
    int bad;
    vec_t v;
    w = 0;
    bad = 0;
    while (bus.key_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    check("key_ready_before_load", 128'(bus.key_ready), 128'd1);
    bus.key_valid = 1'b1;
    bus.key = k;
    if (rd_old) begin
      v.idx = 4'd0; v.err = 1'b0; v.key = fips_rk[0];
      bus.rd_req = 1'b1;
      bus.rd_idx = 4'd0;
      exp_q.push_back(v);
    end
    tick();
    bus.key_valid = 1'b0;
    bus.rd_req = 1'b0;
    check("keys_ready_drops_on_load", 128'(bus.keys_ready), 128'd0);
    for (int c = 0; c < 20; c++) begin
      if (bus.busy !== 1'b1 || bus.keys_ready !== 1'b0 || bus.key_ready !== 1'b0) bad++;
      if (side && c == 3) begin
        bus.rd_req = 1'b1;
        bus.rd_idx = 4'd2;
      end
      if (side && c == 4) begin
        bus.rd_req = 1'b0;
        check("rd_dropped_while_busy", 128'(bus.rd_valid), 128'd0);
      end
      if (side && c == 5) begin
        bus.key_valid = 1'b1;
        bus.key = '1;
      end
      if (side && c == 6) bus.key_valid = 1'b0;
      tick();
    end
    check("busy_window_bad_cycles", 128'(bad), 128'd0);
    check("keys_ready_at_20", 128'(bus.keys_ready), 128'd1);
    check("busy_clear_at_20", 128'(bus.busy), 128'd0);
    check("key_ready_at_20", 128'(bus.key_ready), 128'd1);
    $display("[TB] key %h loaded, waited %0d cycles for key_ready", k, w);
  endtask

  task automatic read_table_fips();
    for (int i = 0; i < 12; i++) issue(fips_vec[i]);
    drain();
  endtask

  initial begin
    fips_key   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[0]  = fips_key;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 0; i < 11; i++) fips_vec[i] = '{idx: 4'(i), err: 1'b0, key: fips_rk[i]};
    fips_vec[11] = '{idx: 4'd11, err: 1'b1, key: 128'h0};
    zero_vec[0] = '{idx: 4'd0, err: 1'b0, key: 128'h0};
    zero_vec[1] = '{idx: 4'd1, err: 1'b0, key: 128'h62636363626363636263636362636363};
    zero_vec[2] = '{idx: 4'd2, err: 1'b0, key: 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};
    zero_vec[3] = '{idx: 4'd15, err: 1'b1, key: 128'h0};

    bus.key_valid = 1'b0;
    bus.key = '0;
    bus.rd_req = 1'b0;
    bus.rd_idx = '0;

    // Reset values
    repeat (3) tick();
    check("reset_key_ready", 128'(bus.key_ready), 128'd0);
    check("reset_busy", 128'(bus.busy), 128'd0);
    check("reset_keys_ready", 128'(bus.keys_ready), 128'd0);
    check("reset_rd_valid", 128'(bus.rd_valid), 128'd0);
    check("reset_rd_err", 128'(bus.rd_err), 128'd0);
    check("reset_rd_key", bus.rd_key, 128'h0);
    reset_n = 1'b1;
    tick();
    check("key_ready_after_release", 128'(bus.key_ready), 128'd1);

    // FIPS-197 expansion with an ignored key and a dropped read mid-flight
    load_key(fips_key, 1'b0, 1'b1);
    read_table_fips();

    // rd_key holds between responses
    issue(fips_vec[10]);
    drain();
    repeat (3) tick();
    check("rd_key_hold", bus.rd_key, fips_rk[10]);
    check("rd_valid_idle", 128'(bus.rd_valid), 128'd0);

    // Second key in DONE with a same-cycle read of the old rk[0]
    load_key(128'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) issue(zero_vec[i]);
    drain();

    // Reset at cycle 7 of an expansion
    bus.key_valid = 1'b1;
    bus.key = fips_key;
    tick();
    bus.key_valid = 1'b0;
    repeat (6) tick();
    reset_n = 1'b0;
    #1;
    check("midreset_key_ready", 128'(bus.key_ready), 128'd0);
    check("midreset_busy", 128'(bus.busy), 128'd0);
    check("midreset_keys_ready", 128'(bus.keys_ready), 128'd0);
    check("midreset_rd_key", bus.rd_key, 128'h0);
    tick();
    reset_n = 1'b1;
    tick();
    check("key_ready_after_midreset", 128'(bus.key_ready), 128'd1);
    bus.rd_req = 1'b1;
    bus.rd_idx = 4'd1;
    tick();
    bus.rd_req = 1'b0;
    check("rd_dropped_after_reset", 128'(bus.rd_valid), 128'd0);
    load_key(fips_key, 1'b0, 1'b0);
    read_table_fips();

`ifdef AES_KEYSCHED_ZEROIZE_EN
    // Zeroize at cycle 9 of an expansion
    bus.key_valid = 1'b1;
    bus.key = 128'h0;
    tick();
    bus.key_valid = 1'b0;
    repeat (8) tick();
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    check("zeroize_busy", 128'(bus.busy), 128'd0);
    check("zeroize_key_ready", 128'(bus.key_ready), 128'd0);
    check("zeroize_keys_ready", 128'(bus.keys_ready), 128'd0);
    check("zeroize_rd_key", bus.rd_key, 128'h0);
    load_key(fips_key, 1'b0, 1'b0);
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    bus.rd_req = 1'b1;
    bus.rd_idx = 4'd3;
    tick();
    bus.rd_req = 1'b0;
    check("rd_dropped_after_zeroize", 128'(bus.rd_valid), 128'd0);
    load_key(128'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) issue(zero_vec[i]);
    drain();
`endif

    repeat (3) tick();
    check("scoreboard_final_empty", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
